// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 valid/ready demultiplexer feeding two independent per-port FIFOs
module stream_demux #(
  parameter int N = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 in_data,
  input  logic                         in_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N-1:0]                 a_data,
  output logic                         a_valid,
  input  logic                         a_ready,
  output logic [N-1:0]                 b_data,
  output logic                         b_valid,
  input  logic                         b_ready,
  output logic [$clog2(DEPTH+1)-1:0]   a_count,
  output logic [$clog2(DEPTH+1)-1:0]   b_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [1:0] rdy;
  assign rdy = {a_ready, b_ready};
  assign in_ready = !rst && (in_sel ? g_fifo[1].cnt != CW'(DEPTH) : g_fifo[0].cnt != CW'(DEPTH));
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] head;
    logic [CW-1:0] cnt;
    logic [PW-1:0] rp, wp, rn;
    logic push, pop;
    assign push = in_valid && in_ready && (in_sel == 1'(g));
    assign pop = (cnt != '0) && rdy[g];
    assign rn = rp + 1'b1;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        rp <= '0;
        wp <= '0;
        head <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wp] <= in_data;
          wp <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
        if (push && (cnt == '0 || (cnt == CW'(1) && pop))) head <= in_data;
        else if (pop && cnt > CW'(1)) head <= mem[rn];
      end
    end
  end
  assign a_data = g_fifo[1].head;
  assign a_valid = g_fifo[1].cnt != '0;
  assign a_count = g_fifo[1].cnt;
  assign b_data = g_fifo[0].head;
  assign b_valid = g_fifo[0].cnt != '0;
  assign b_count = g_fifo[0].cnt;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed and random scoreboard bench for stream_demux
module tb_stream_demux;
  localparam int N = 8;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] in_data;
  logic in_sel, in_valid, in_ready;
  logic [N-1:0] a_data, b_data;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [CW-1:0] a_count, b_count;
  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];
  logic sa = 0, sb = 0;
  logic [N-1:0] da, db;

  stream_demux #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      sa = 0;
      sb = 0;
    end else begin
      if (sa) chk("a_hold", {a_valid, a_data}, {1'b1, da});
      if (sb) chk("b_hold", {b_valid, b_data}, {1'b1, db});
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL a_extra: got %0h expected no beat", a_data);
        end else chk("a_order", a_data, qa.pop_front());
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL b_extra: got %0h expected no beat", b_data);
        end else chk("b_order", b_data, qb.pop_front());
      end
      sa = a_valid && !a_ready;
      da = a_data;
      sb = b_valid && !b_ready;
      db = b_data;
      if (in_valid && in_ready) begin
        if (in_sel) qa.push_back(in_data);
        else qb.push_back(in_data);
      end
    end
  end

  initial begin
    in_valid = 1; in_sel = 1; in_data = 8'h99; a_ready = 0; b_ready = 0;
    repeat (2) begin
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_a_count", a_count, 0);
      chk("rst_b_count", b_count, 0);
      chk("rst_a_data", a_data, 0);
    end
    in_valid = 0; rst = 0; #1;
    chk("rel_in_ready", in_ready, 1);
    // routing
    a_ready = 1; b_ready = 1; in_valid = 1; in_sel = 1; in_data = 8'h11;
    step();
    in_sel = 0; in_data = 8'h22; #1;
    chk("route_a_valid", a_valid, 1);
    chk("route_a_data", a_data, 8'h11);
    chk("route_b_early", b_valid, 0);
    step();
    in_valid = 0; #1;
    chk("route_a_gone", a_valid, 0);
    chk("route_b_valid", b_valid, 1);
    chk("route_b_data", b_data, 8'h22);
    step();
    chk("route_b_gone", b_valid, 0);
    // backpressure on A
    a_ready = 0; in_valid = 1; in_sel = 1; in_data = 8'hA1; #1;
    chk("bp_rdy1", in_ready, 1);
    step();
    in_data = 8'hA2; #1;
    chk("bp_rdy2", in_ready, 1);
    chk("bp_cnt1", a_count, 1);
    step();
    in_data = 8'hA3; #1;
    chk("bp_cnt2", a_count, 2);
    chk("bp_full", in_ready, 0);
    step();
    chk("bp_refused", a_count, 2);
    chk("bp_full2", in_ready, 0);
    in_sel = 0; in_data = 8'hB0; #1;
    chk("bp_b_rdy", in_ready, 1);
    step();
    in_valid = 0; #1;
    chk("bp_b_valid", b_valid, 1);
    chk("bp_b_data", b_data, 8'hB0);
    chk("bp_a_head", a_data, 8'hA1);
    a_ready = 1;
    step();
    chk("bp_a_next", a_data, 8'hA2);
    chk("bp_a_cnt", a_count, 1);
    step();
    chk("bp_a_empty", a_count, 0);
    chk("bp_a_nv", a_valid, 0);
    // simultaneous push and pop
    a_ready = 0; in_valid = 1; in_sel = 1; in_data = 8'h44;
    step();
    a_ready = 1; in_data = 8'h55; #1;
    chk("pp_cnt_before", a_count, 1);
    chk("pp_rdy", in_ready, 1);
    step();
    in_valid = 0; #1;
    chk("pp_cnt_after", a_count, 1);
    chk("pp_head", a_data, 8'h55);
    step();
    chk("pp_drained", a_count, 0);
    // full with consumer ready: no pass-through
    a_ready = 0; in_valid = 1; in_data = 8'h61;
    step();
    in_data = 8'h62;
    step();
    a_ready = 1; in_data = 8'h63; #1;
    chk("fr_cnt", a_count, 2);
    chk("fr_no_pass", in_ready, 0);
    step();
    in_valid = 0; #1;
    chk("fr_cnt_pop", a_count, 1);
    chk("fr_head", a_data, 8'h62);
    step();
    chk("fr_drained", a_count, 0);
    // random stream
    begin
      int acc_n;
      int cyc;
      logic acc;
      acc_n = 0; cyc = 0; acc = 0;
      while (acc_n < 1000 && cyc < 20000) begin
        if (!in_valid || acc) begin
          in_valid = $urandom_range(0, 3) != 0;
          in_sel = 1'($urandom_range(0, 1));
          in_data = 8'($urandom);
        end
        a_ready = $urandom_range(0, 3) != 0;
        b_ready = 1'($urandom_range(0, 1));
        #1;
        acc = in_valid && in_ready;
        if (acc) acc_n++;
        step();
        cyc++;
      end
      chk("rand_beats", acc_n, 1000);
      in_valid = 0; a_ready = 1; b_ready = 1;
      repeat (DEPTH + 2) step();
      chk("rand_a_drained", qa.size(), 0);
      chk("rand_b_drained", qb.size(), 0);
    end
    // mid-stream reset
    a_ready = 0; b_ready = 0; in_valid = 1; in_sel = 1; in_data = 8'hC1;
    step();
    in_data = 8'hC2;
    step();
    in_sel = 0; in_data = 8'hD1;
    step();
    in_valid = 0; #1;
    chk("mr_a_cnt", a_count, 2);
    chk("mr_b_cnt", b_count, 1);
    rst = 1;
    step();
    rst = 0; #1;
    chk("mr_a_valid", a_valid, 0);
    chk("mr_b_valid", b_valid, 0);
    chk("mr_a_count", a_count, 0);
    chk("mr_b_count", b_count, 0);
    chk("mr_a_data", a_data, 0);
    a_ready = 1; b_ready = 1;
    repeat (4) step();
    chk("mr_a_stale", a_valid, 0);
    chk("mr_b_stale", b_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
